// File: rtl/hwpe_stream_tcdm_slice_if.sv
// hwpe_stream_intf_tcdm: one TCDM request/response channel.
// A master drives the request fields and receives the grant and the response.
// A slave receives the request fields and returns the grant and the response.
interface hwpe_stream_intf_tcdm #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) ();
   logic            req;
   logic            gnt;
   logic [AW-1:0]   add;
   logic            wen;
   logic [DW/8-1:0] be;
   logic [DW-1:0]   data;
   logic [DW-1:0]   r_data;
   logic            r_valid;

   modport master (output req, add, wen, be, data, input  gnt, r_data, r_valid);
   modport slave  (input  req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_slice.sv
// hwpe_stream_tcdm_slice: registered TCDM request slice for NB_CHAN channels.
// Each channel has an in-order request FIFO of DEPTH entries. The slave grant
// depends only on the registered fill level, so the req/gnt path is cut.
// Responses return in order. An outstanding counter per channel feeds the
// idle flags.
// Optional feature: define HWPE_STREAM_TCDM_SLICE_RESP_REG_EN to register
// r_valid/r_data on their way back to the slave. This adds one cycle of
// response latency.

// Protocol checker for one channel. It holds only assertions.
module hwpe_stream_tcdm_slice_chk #(
   parameter int unsigned OW      = 2,
   parameter int unsigned OUT_MAX = 2,
   parameter int unsigned EW      = 69
) (
   input logic          clk_i,
   input logic          rst_i,
   input logic          inc_i,
   input logic          dec_i,
   input logic [OW-1:0] out_i,
   input logic          req_i,
   input logic          gnt_i,
   input logic [EW-1:0] head_i
);
   logic          stall_q;
   logic [EW-1:0] head_q;

   // Remember whether the master side was stalled and what it showed then.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= 1'b0;
         head_q  <= {EW{1'b0}};
      end else begin
         stall_q <= req_i & ~gnt_i;
         head_q  <= head_i;
      end
   end

   // Outstanding counter must stay within 0..OUT_MAX.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (inc_i && !dec_i) begin
            assert (out_i < OW'(OUT_MAX));
         end
         if (dec_i && !inc_i) begin
            assert (out_i != OW'(0));
         end
      end
   end

   // A stalled request is neither retracted nor changed.
   always_ff @(posedge clk_i) begin
      if (!rst_i && stall_q) begin
         assert (req_i && (head_i == head_q));
      end
   end
endmodule

module hwpe_stream_tcdm_slice #(
   parameter int unsigned NB_CHAN = 4,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   hwpe_stream_intf_tcdm.slave  tcdm_slave  [NB_CHAN-1:0],
   hwpe_stream_intf_tcdm.master tcdm_master [NB_CHAN-1:0],
   output logic [NB_CHAN-1:0]   idle_chan_o,
   output logic                 idle_o
);
   localparam int unsigned BW = DW / 8;
   localparam int unsigned EW = AW + DW + BW + 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
`ifdef HWPE_STREAM_TCDM_SLICE_RESP_REG_EN
   localparam int unsigned OW      = 3;
   localparam int unsigned OUT_MAX = 3;
`else
   localparam int unsigned OW      = 2;
   localparam int unsigned OUT_MAX = 2;
`endif

   for (genvar g = 0; g < NB_CHAN; g++) begin : gen_chan
      logic [EW-1:0] mem_q [DEPTH];
      logic [EW-1:0] wdata_s;
      logic [EW-1:0] head_s;
      logic [PW-1:0] wptr_q, wptr_d;
      logic [PW-1:0] rptr_q, rptr_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [OW-1:0] out_q, out_d;
      logic          gnt_s, req_s, push_s, pop_s;
      logic          resp_valid_s;
      logic [DW-1:0] resp_data_s;

      assign gnt_s   = (cnt_q != CW'(DEPTH));
      assign req_s   = (cnt_q != CW'(0));
      assign push_s  = tcdm_slave[g].req & gnt_s;
      assign pop_s   = req_s & tcdm_master[g].gnt;
      assign wdata_s = {tcdm_slave[g].add, tcdm_slave[g].data, tcdm_slave[g].be, tcdm_slave[g].wen};
      assign head_s  = mem_q[rptr_q];

      assign tcdm_slave[g].gnt   = gnt_s;
      assign tcdm_master[g].req  = req_s;
      assign tcdm_master[g].add  = head_s[EW-1 -: AW];
      assign tcdm_master[g].data = head_s[BW+DW : BW+1];
      assign tcdm_master[g].be   = head_s[BW : 1];
      assign tcdm_master[g].wen  = head_s[0];

      // Pointer advance with wrap from DEPTH-1 back to 0.
      always_comb begin
         wptr_d = wptr_q;
         rptr_d = rptr_q;
         if (push_s) begin
            if (wptr_q == PW'(DEPTH - 1)) wptr_d = PW'(0);
            else                          wptr_d = wptr_q + PW'(1);
         end else begin
            wptr_d = wptr_q;
         end
         if (pop_s) begin
            if (rptr_q == PW'(DEPTH - 1)) rptr_d = PW'(0);
            else                          rptr_d = rptr_q + PW'(1);
         end else begin
            rptr_d = rptr_q;
         end
      end

      // Fill level: a simultaneous push and pop leaves it unchanged.
      always_comb begin
         cnt_d = cnt_q;
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end

      // Outstanding responses: +1 on pop, -1 on slave-side r_valid.
      always_comb begin
         out_d = out_q;
         case ({pop_s, resp_valid_s})
            2'b10: out_d = out_q + OW'(1);
            2'b01: begin
               if (out_q != OW'(0)) out_d = out_q - OW'(1);
               else                 out_d = out_q;
            end
            default: out_d = out_q;
         endcase
      end

      // Channel state registers.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            wptr_q <= PW'(0);
            rptr_q <= PW'(0);
            cnt_q  <= CW'(0);
            out_q  <= OW'(0);
         end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
         end
      end

      // FIFO storage: write the incoming entry at the write pointer.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= {EW{1'b0}};
         end else if (push_s) begin
            mem_q[wptr_q] <= wdata_s;
         end
      end

`ifdef HWPE_STREAM_TCDM_SLICE_RESP_REG_EN
      logic          rvalid_q;
      logic [DW-1:0] rdata_q;

      // Response register. A response in flight at reset is discarded.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= {DW{1'b0}};
         end else begin
            rvalid_q <= tcdm_master[g].r_valid;
            rdata_q  <= tcdm_master[g].r_data;
         end
      end

      assign resp_valid_s = rvalid_q;
      assign resp_data_s  = rdata_q;
`else
      assign resp_valid_s = tcdm_master[g].r_valid;
      assign resp_data_s  = tcdm_master[g].r_data;
`endif

      assign tcdm_slave[g].r_valid = resp_valid_s;
      assign tcdm_slave[g].r_data  = resp_data_s;
      assign idle_chan_o[g]        = (cnt_q == CW'(0)) && (out_q == OW'(0));

      hwpe_stream_tcdm_slice_chk #(
         .OW      (OW),
         .OUT_MAX (OUT_MAX),
         .EW      (EW)
      ) i_chk (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .inc_i  (pop_s),
         .dec_i  (resp_valid_s),
         .out_i  (out_q),
         .req_i  (req_s),
         .gnt_i  (tcdm_master[g].gnt),
         .head_i (head_s)
      );
   end

   assign idle_o = &idle_chan_o;
endmodule

// File: tb/tb_hwpe_stream_tcdm_slice.sv
// Testbench for hwpe_stream_tcdm_slice: scoreboard-based.
// The slave-side driver pushes the expected requests and responses for each
// accepted request. A TCDM model answers every master grant one cycle later
// with r_data = ~add. A monitor pops the queues and compares.
module tb_hwpe_stream_tcdm_slice;
   localparam int NB_CHAN = 4;
`ifdef HWPE_STREAM_TCDM_SLICE_RESP_REG_EN
   localparam int RESP_LAT = 2;
`else
   localparam int RESP_LAT = 1;
`endif

   typedef struct packed {
      logic [31:0] add;
      logic [31:0] data;
      logic [3:0]  be;
      logic        wen;
      logic        exact;
      logic [31:0] cyc;
   } req_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [NB_CHAN-1:0] s_req, s_gnt, s_wen, s_rvalid;
   logic [NB_CHAN-1:0] m_req, m_gnt, m_wen, m_rvalid;
   logic [31:0] s_add [NB_CHAN];
   logic [31:0] s_data [NB_CHAN];
   logic [31:0] s_rdata [NB_CHAN];
   logic [3:0]  s_be [NB_CHAN];
   logic [31:0] m_add [NB_CHAN];
   logic [31:0] m_data [NB_CHAN];
   logic [31:0] m_rdata [NB_CHAN];
   logic [3:0]  m_be [NB_CHAN];
   logic [NB_CHAN-1:0] idle_chan;
   logic idle;

   req_t        send_q     [NB_CHAN][$];
   req_t        exp_req_q  [NB_CHAN][$];
   logic [31:0] exp_resp_q [NB_CHAN][$];
   int          resp_cyc_q [NB_CHAN][$];
   int          acc_cnt    [NB_CHAN];

   hwpe_stream_intf_tcdm #(.AW(32), .DW(32)) slv_if [NB_CHAN-1:0] ();
   hwpe_stream_intf_tcdm #(.AW(32), .DW(32)) mst_if [NB_CHAN-1:0] ();

   for (genvar g = 0; g < NB_CHAN; g++) begin : gen_if
      assign slv_if[g].req     = s_req[g];
      assign slv_if[g].add     = s_add[g];
      assign slv_if[g].data    = s_data[g];
      assign slv_if[g].be      = s_be[g];
      assign slv_if[g].wen     = s_wen[g];
      assign s_gnt[g]          = slv_if[g].gnt;
      assign s_rvalid[g]       = slv_if[g].r_valid;
      assign s_rdata[g]        = slv_if[g].r_data;
      assign m_req[g]          = mst_if[g].req;
      assign m_add[g]          = mst_if[g].add;
      assign m_data[g]         = mst_if[g].data;
      assign m_be[g]           = mst_if[g].be;
      assign m_wen[g]          = mst_if[g].wen;
      assign mst_if[g].gnt     = m_gnt[g];
      assign mst_if[g].r_valid = m_rvalid[g];
      assign mst_if[g].r_data  = m_rdata[g];
   end

   hwpe_stream_tcdm_slice #(
      .NB_CHAN (NB_CHAN),
      .DEPTH   (2),
      .AW      (32),
      .DW      (32)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .tcdm_slave  (slv_if),
      .tcdm_master (mst_if),
      .idle_chan_o (idle_chan),
      .idle_o      (idle)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave-side driver: presents queued requests and records accepted ones.
   initial begin
      s_req = '0;
      s_wen = '0;
      for (int c = 0; c < NB_CHAN; c++) begin
         s_add[c] = 32'h0; s_data[c] = 32'h0; s_be[c] = 4'h0; acc_cnt[c] = 0;
      end
      forever begin
         @(posedge clk); #1;
         for (int c = 0; c < NB_CHAN; c++) begin
            if (send_q[c].size() > 0) begin
               s_req[c]  = 1'b1;
               s_add[c]  = send_q[c][0].add;
               s_data[c] = send_q[c][0].data;
               s_be[c]   = send_q[c][0].be;
               s_wen[c]  = send_q[c][0].wen;
            end else begin
               s_req[c] = 1'b0;
            end
         end
         @(negedge clk);
         for (int c = 0; c < NB_CHAN; c++) begin
            if (s_req[c] && s_gnt[c] && !rst) begin
               req_t e;
               e = send_q[c].pop_front();
               e.cyc = 32'(cyc);
               exp_req_q[c].push_back(e);
               exp_resp_q[c].push_back(~e.add);
               acc_cnt[c]++;
            end
         end
      end
   end

   // TCDM model: every master grant gets r_valid one cycle later.
   initial begin
      logic [NB_CHAN-1:0] pend;
      logic [31:0]        pend_data [NB_CHAN];
      m_rvalid = '0;
      for (int c = 0; c < NB_CHAN; c++) begin
         m_rdata[c] = 32'h0; pend_data[c] = 32'h0;
      end
      forever begin
         @(negedge clk);
         pend = m_req & m_gnt;
         for (int c = 0; c < NB_CHAN; c++) pend_data[c] = ~m_add[c];
         @(posedge clk); #1;
         m_rvalid = pend;
         for (int c = 0; c < NB_CHAN; c++) m_rdata[c] = pend_data[c];
      end
   end

   // Monitor: compares master requests, stall stability and slave responses.
   initial begin
      logic [NB_CHAN-1:0] prev_stall = '0;
      logic [31:0]        prev_add [NB_CHAN];
      logic [31:0]        prev_data [NB_CHAN];
      forever begin
         @(negedge clk);
         for (int c = 0; c < NB_CHAN; c++) begin
            if (rst) begin
               prev_stall[c] = 1'b0;
            end else begin
               if (prev_stall[c]) begin
                  chk($sformatf("ch%0d stall req", c), 64'(m_req[c]), 64'(1));
                  chk($sformatf("ch%0d stall add", c), 64'(m_add[c]), 64'(prev_add[c]));
                  chk($sformatf("ch%0d stall data", c), 64'(m_data[c]), 64'(prev_data[c]));
               end
               prev_stall[c] = m_req[c] & ~m_gnt[c];
               prev_add[c]   = m_add[c];
               prev_data[c]  = m_data[c];
               if (m_req[c] && m_gnt[c]) begin
                  if (exp_req_q[c].size() == 0) begin
                     chk($sformatf("ch%0d unexpected master grant", c), 64'(0), 64'(1));
                  end else begin
                     req_t e;
                     e = exp_req_q[c].pop_front();
                     chk($sformatf("ch%0d master add", c), 64'(m_add[c]), 64'(e.add));
                     chk($sformatf("ch%0d master data", c), 64'(m_data[c]), 64'(e.data));
                     chk($sformatf("ch%0d master be", c), 64'(m_be[c]), 64'(e.be));
                     chk($sformatf("ch%0d master wen", c), 64'(m_wen[c]), 64'(e.wen));
                     if (e.exact) chk($sformatf("ch%0d req latency", c), 64'(cyc), 64'(e.cyc + 32'd1));
                     else         chk($sformatf("ch%0d req latency>=1", c), 64'(cyc > int'(e.cyc)), 64'(1));
                     resp_cyc_q[c].push_back(cyc + RESP_LAT);
                  end
               end
               if (s_rvalid[c]) begin
                  if (exp_resp_q[c].size() == 0 || resp_cyc_q[c].size() == 0) begin
                     chk($sformatf("ch%0d unexpected r_valid", c), 64'(0), 64'(1));
                  end else begin
                     chk($sformatf("ch%0d r_data", c), 64'(s_rdata[c]), 64'(exp_resp_q[c].pop_front()));
                     chk($sformatf("ch%0d resp cycle", c), 64'(cyc), 64'(resp_cyc_q[c].pop_front()));
                  end
               end else if (resp_cyc_q[c].size() > 0 && resp_cyc_q[c][0] < cyc) begin
                  chk($sformatf("ch%0d missing r_valid", c), 64'(0), 64'(1));
                  void'(resp_cyc_q[c].pop_front());
                  if (exp_resp_q[c].size() > 0) void'(exp_resp_q[c].pop_front());
               end
            end
         end
      end
   end

   function automatic bit ch_empty(int c);
      return send_q[c].size() == 0 && exp_req_q[c].size() == 0 &&
             exp_resp_q[c].size() == 0 && resp_cyc_q[c].size() == 0;
   endfunction

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic push_req(input int c, input logic [31:0] add, input logic [31:0] data,
                           input logic [3:0] be, input logic wen, input logic exact);
      req_t e;
      e.add = add; e.data = data; e.be = be; e.wen = wen; e.exact = exact; e.cyc = 32'h0;
      send_q[c].push_back(e);
   endtask

   task automatic wait_drain(input string name, input int max);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < max) begin
         @(negedge clk);
         done = ch_empty(0) && ch_empty(1) && ch_empty(2) && ch_empty(3) && (idle === 1'b1);
         n++;
      end
      chk(name, 64'(done), 64'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int n;
      rst   = 1'b1;
      m_gnt = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("reset slave gnt", 64'(s_gnt), 64'(4'hF));
      chk("reset master req", 64'(m_req), 64'(4'h0));
      chk("reset idle_chan", 64'(idle_chan), 64'(4'hF));
      chk("reset idle", 64'(idle), 64'(1));
      chk("reset slave r_valid", 64'(s_rvalid), 64'(4'h0));

      // Back-to-back reads on ch0 with master gnt tied high.
      step();
      m_gnt = 4'hF;
      for (int i = 0; i < 8; i++) push_req(0, 32'h100 + 32'(4 * i), 32'(i), 4'hF, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("b2b slave gnt", 64'(s_gnt[0]), 64'(1));
      end
      wait_drain("b2b drain", 40);
      chk("b2b idle", 64'(idle), 64'(1));

      // Backpressure: ch0 master gnt low for 5 cycles.
      step();
      m_gnt[0] = 1'b0;
      n = acc_cnt[0];
      for (int i = 0; i < 4; i++) push_req(0, 32'h300 + 32'(4 * i), 32'hA000 + 32'(i), 4'hF, 1'b1, 1'b0);
      repeat (5) step();
      @(negedge clk);
      chk("bp slave gnt", 64'(s_gnt[0]), 64'(0));
      chk("bp accepted", 64'(acc_cnt[0] - n), 64'(2));
      chk("bp master req", 64'(m_req[0]), 64'(1));
      step();
      m_gnt[0] = 1'b1;
      wait_drain("bp drain", 40);

      // Write path.
      step();
      push_req(0, 32'h200, 32'hDEADBEEF, 4'b0101, 1'b0, 1'b0);
      wait_drain("write drain", 20);
      chk("write idle ch0", 64'(idle_chan[0]), 64'(1));

      // Channel isolation: ch1 stalled while ch0 and ch2 stream.
      step();
      m_gnt[1] = 1'b0;
      t0 = cyc;
      push_req(1, 32'h500, 32'h5, 4'hF, 1'b1, 1'b0);
      push_req(1, 32'h504, 32'h6, 4'hF, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         push_req(0, 32'h1000 + 32'(4 * i), 32'(i), 4'hF, 1'b1, 1'b1);
         push_req(2, 32'h2000 + 32'(4 * i), 32'(i), 4'hF, 1'b0, 1'b1);
      end
      n = 0;
      while (!(ch_empty(0) && ch_empty(2)) && n < 60) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("iso full rate", 64'((cyc - t0) <= 22), 64'(1));
      chk("iso idle ch0", 64'(idle_chan[0]), 64'(1));
      chk("iso idle ch2", 64'(idle_chan[2]), 64'(1));
      chk("iso idle ch1", 64'(idle_chan[1]), 64'(0));
      chk("iso idle", 64'(idle), 64'(0));
      step();
      m_gnt[1] = 1'b1;
      wait_drain("iso drain", 40);
      chk("iso idle after drain", 64'(idle), 64'(1));

      // Reset with two requests buffered on ch3.
      step();
      m_gnt[3] = 1'b0;
      push_req(3, 32'h700, 32'h7, 4'hF, 1'b1, 1'b0);
      push_req(3, 32'h704, 32'h8, 4'hF, 1'b1, 1'b0);
      repeat (4) step();
      @(negedge clk);
      chk("pre-reset ch3 req", 64'(m_req[3]), 64'(1));
      chk("pre-reset ch3 gnt", 64'(s_gnt[3]), 64'(0));
      step();
      rst = 1'b1;
      exp_req_q[3].delete();
      exp_resp_q[3].delete();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post-reset ch3 req", 64'(m_req[3]), 64'(0));
      chk("post-reset ch3 gnt", 64'(s_gnt[3]), 64'(1));
      chk("post-reset idle ch3", 64'(idle_chan[3]), 64'(1));
      step();
      m_gnt[3] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no spurious req ch3", 64'(m_req[3]), 64'(0));
      end
      step();
      push_req(3, 32'h800, 32'h9, 4'hF, 1'b1, 1'b1);
      wait_drain("post-reset drain", 20);

      // Single read: response latency and data.
      step();
      push_req(0, 32'h900, 32'h0, 4'hF, 1'b1, 1'b1);
      wait_drain("single read drain", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
